// File: rtl/ud_counter_pkg.sv
// rtl/ud_counter_pkg.sv - shared constants and helpers for the ud_counter up/down counter
package ud_counter_pkg;

    localparam int UD_COUNTER_WIDTH_DEF = 4;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    // Computed in 33 bits so that width=32 does not overflow the shift.
    function automatic logic [31:0] ud_all_ones(input int unsigned width);
        logic [32:0] v;
        v = (33'd1 << width) - 33'd1;
        return v[31:0];
    endfunction

endpackage

// File: rtl/ud_counter_step.sv
// rtl/ud_counter_step.sv - combinational next-count and terminal-count logic (UD_COUNTER_SAT_EN selects saturate vs wrap)
module ud_counter_step
    import ud_counter_pkg::*;
#(
    parameter int WIDTH = UD_COUNTER_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic             e,
    input  logic             u,
    output logic [WIDTH-1:0] cnt_next,
    output logic             tc
);

    localparam logic [31:0]      CNT_MAX_32 = ud_all_ones(WIDTH);
    localparam logic [WIDTH-1:0] CNT_MAX    = CNT_MAX_32[WIDTH-1:0];

`ifdef UD_COUNTER_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    logic at_max;
    logic at_zero;

    assign at_max  = (cnt == CNT_MAX);
    assign at_zero = (cnt == '0);

    // Tc marks the boundary the next enabled edge crosses: wrap point or saturation point.
    assign tc = e & (((u == DIR_UP) & at_max) | ((u == DIR_DOWN) & at_zero));

    always_comb begin
        cnt_next = cnt;
        if (e) begin
            if (u == DIR_UP) begin
                cnt_next = (at_max && SAT_EN) ? cnt : cnt + 1'b1;
            end else begin
                cnt_next = (at_zero && SAT_EN) ? cnt : cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ud_counter.sv
// rtl/ud_counter.sv - up/down counter top: async-reset count register around ud_counter_step (option macro UD_COUNTER_SAT_EN)
module ud_counter
    import ud_counter_pkg::*;
#(
    parameter int WIDTH = UD_COUNTER_WIDTH_DEF
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             E,
    input  logic             U,
    output logic [WIDTH-1:0] Cnt,
    output logic             Tc
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    ud_counter_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .cnt      (cnt_q),
        .e        (E),
        .u        (U),
        .cnt_next (cnt_d),
        .tc       (Tc)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Cnt = cnt_q;

endmodule

// File: tb/tb_ud_counter.sv
// tb/tb_ud_counter.sv - scoreboard bench for ud_counter against an arithmetic reference model
module tb_ud_counter;

    localparam int W    = 4;
    localparam int MODV = 1 << W;
    localparam int MAXV = MODV - 1;

    logic         Clk = 1'b0;
    logic         Rst = 1'b0;
    logic         E   = 1'b0;
    logic         U   = 1'b0;
    logic [W-1:0] Cnt;
    logic         Tc;

    ud_counter #(.WIDTH(W)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .E   (E),
        .U   (U),
        .Cnt (Cnt),
        .Tc  (Tc)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int cnt;
        bit tc;
        int phase;
    } exp_t;

    exp_t exp_q[$];
    event sample_ev;
    int   vectors     = 0;
    int   miscompares = 0;
    int   model       = 0;
    int   phase       = 0;

    function automatic int model_next(int c, bit e, bit u);
        if (!e) return c;
        if (u) begin
`ifdef UD_COUNTER_SAT_EN
            if (c == MAXV) return c;
`endif
            return (c + 1) % MODV;
        end
`ifdef UD_COUNTER_SAT_EN
        if (c == 0) return 0;
`endif
        return (c + MODV - 1) % MODV;
    endfunction

    function automatic bit model_tc(int c, bit e, bit u);
        return e && ((u && c == MAXV) || (!u && c == 0));
    endfunction

    task automatic push_expect(bit e, bit u);
        exp_t x;
        x.cnt   = model;
        x.tc    = model_tc(model, e, u);
        x.phase = phase;
        exp_q.push_back(x);
        -> sample_ev;
    endtask

    // One cycle: drive at the falling edge, check the pre-edge state, advance the model.
    task automatic apply(bit rst, bit e, bit u);
        @(negedge Clk);
        Rst = rst;
        E   = e;
        U   = u;
        #1;
        if (!rst) model = 0;
        push_expect(e, u);
        if (rst) model = model_next(model, e, u);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(sample_ev);
            while (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                vectors++;
                if (int'(Cnt) != x.cnt || Tc !== x.tc) begin
                    miscompares++;
                    $display("FAIL cnt/tc phase=%0d t=%0t got cnt=%0d tc=%0b exp cnt=%0d tc=%0b",
                             x.phase, $time, Cnt, Tc, x.cnt, x.tc);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL timeout t=%0t got=running exp=finished", $time);
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : stimulus
        int guard;
        // Reset held with E=1 and U toggling
        phase = 1;
        apply(0, 1, 0);
        apply(0, 1, 1);
        apply(0, 1, 0);
        // Up with wrap
        phase = 2;
        for (int i = 0; i < 21; i++) apply(1, 1, 1);
        // Down with wrap
        phase = 3;
        for (int i = 0; i < 18; i++) apply(1, 1, 0);
        // Hold with both directions
        phase = 4;
        apply(1, 0, 0);
        apply(1, 0, 0);
        apply(1, 0, 1);
        apply(1, 0, 1);
        // Count down to 9, then async reset between edges
        phase = 5;
        guard = 0;
        while (model != 9 && guard < 40) begin
            apply(1, 1, 0);
            guard++;
        end
        @(posedge Clk);
        #3;
        Rst = 1'b0;
        #1;
        model = 0;
        push_expect(E, U);
        apply(0, 1, 0);
        apply(1, 1, 0);
        apply(1, 1, 0);
        apply(1, 1, 0);
        // Randomised run with occasional reset
        phase = 6;
        for (int i = 0; i < 300; i++) begin
            apply(($urandom_range(0, 31) != 0), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
        end
        apply(1, 0, 0);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ud_counter.md
# ud_counter

Parameterised synchronous up/down binary counter with count-enable, direction select and a terminal-count flag. Default width is 4 bits. It is a leaf datapath block used wherever a bidirectional event or position count is needed. It can be cascaded through its terminal-count output to build wider counters.

## Interface
Parameters:
- WIDTH, default 4, counter width in bits; legal range is 2 to 32.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous, active-low reset; clears the counter.
- E  input  1  count enable; 1 means count on this edge, 0 means hold.
- U  input  1  direction; 1 counts up, 0 counts down.
- Cnt  output  WIDTH  current count, registered.
- Tc  output  1  terminal count, combinational; high when the next enabled edge will wrap (or saturate).

## Operation
- Reset: while Rst=0, Cnt=0 immediately, regardless of Clk, E or U. Reset takes priority over everything else.
- On each rising Clk edge with Rst=1:
  - E=0: Cnt holds its value. U is ignored.
  - E=1, U=1: Cnt <= Cnt+1 modulo 2^WIDTH. Maximum (all ones) wraps to 0.
  - E=1, U=0: Cnt <= Cnt-1 modulo 2^WIDTH. Zero wraps to all ones.
- Tc = E & ((U & Cnt==all-ones) | (~U & Cnt==0)).
  - Tc depends only on current E, U and Cnt. It is never registered.
  - Tc is 0 while Rst=0 unless E=1 and U=0. That case is correct, because Cnt=0 then.
- Arithmetic is unsigned WIDTH-bit. Any carry or borrow out of the top bit is discarded; Tc reports it.
- A direction change takes effect on the next enabled edge. There is no dead cycle.
- E and U are sampled only at rising edges. Glitches between edges have no effect on Cnt.

## Timing
- Latency: a count change is visible on Cnt one clock edge after E/U are sampled.
- Reset assertion clears Cnt asynchronously, within the same delta/propagation.
- Reset deassertion is synchronised by the caller. The first count occurs on the first rising edge at which Rst=1 and E=1.
- Reset asserted mid-count aborts the sequence. After release, counting resumes from 0.
- Throughput: one increment or decrement per clock.
- Reset values: Cnt=0. Tc follows the formula (0 unless E=1 and U=0).

## Configuration
- Macro UD_COUNTER_SAT_EN.
- Defined: the counter saturates instead of wrapping.
  - Up at all-ones holds all-ones.
  - Down at 0 holds 0.
  - Tc keeps the same formula and flags the saturation boundary.
- Undefined (default): modulo wrap-around as described in Operation.

## Structure
- Package ud_counter_pkg holds:
  - the UD_COUNTER_WIDTH_DEF constant (4);
  - the direction constants DIR_DOWN=0 and DIR_UP=1;
  - a function returning the all-ones value for a given width.
- One sub-module, ud_counter_step:
  - purely combinational next-value and Tc logic;
  - inputs Cnt, E, U; outputs next Cnt and Tc;
  - contains the wrap/saturate selection.
- The top level holds only the async-reset register and the instantiation of ud_counter_step.

## Test plan
- Reset: hold Rst=0 for 3 edges with E=1 and U toggling -> Cnt stays 0 throughout. Assert Rst=0 between edges -> Cnt goes to 0 without a clock edge.
- Up with wrap: Rst=1, E=1, U=1 for 20 edges from 0 -> Cnt goes 1..15, 0, 1..4. Tc=1 only while Cnt=15.
- Down with wrap: from Cnt=4, E=1, U=0 for 17 edges -> 3, 2, 1, 0, 15, 14, ..., 4, 3. Tc=1 only while Cnt=0.
- Hold: E=0 with U=0, then E=0 with U=1, for 2 edges each -> Cnt unchanged and Tc=0.
- Mid-operation reset: counting down at Cnt=9, assert Rst=0 for one cycle, then release with E=1 and U=0 -> Cnt=0, then 15 on the next edge.
- UD_COUNTER_SAT_EN defined: up from 13 for 5 edges -> 14, 15, 15, 15, 15. Down from 2 for 4 edges -> 1, 0, 0, 0.
